pc_sequencer: RTL and testbench

Sequences the uniciclo datapath around the next-PC mux. It owns the PC register and runs a FETCH/EXEC handshake with instruction memory. It decodes branch and jump control plus ALU flags into the 2-bit PCSrc select for the mux, then loads the mux result (pc_next) back into PC. It also gates architectural writes, detects misaligned targets, and counts retired instructions.

---
 rtl/pc_sequencer.sv | 110 +++++++++++
 tb/tb_pc_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// PC sequencer for the single-cycle datapath: owns the PC, runs the FETCH/EXEC
// handshake with instruction memory, decodes the next-PC mux select and counts retirements.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR     = 32'h0000_0000,
  parameter bit          HALT_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch,
  input  logic        jal,
  input  logic        jalr,
  input  logic [2:0]  funct3,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        alu_ltu,
  input  logic [31:0] pc_next,
  output logic [31:0] pc,
  output logic [1:0]  pc_src,
  output logic        imem_req,
  output logic        exec_en,
  output logic        trap,
  output logic [1:0]  state,
  output logic [31:0] retire_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    HALT  = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retire_q, retire_d;
  logic        trap_q, trap_d;
  logic        taken;
  logic        misalign;

  always_comb begin
    case (funct3)
      3'b000:  taken = alu_zero;
      3'b001:  taken = !alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = !alu_lt;
      3'b110:  taken = alu_ltu;
      3'b111:  taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  // jalr outranks jal, which outranks a taken branch; 2'b11 is never produced.
  always_comb begin
    if (jalr)                pc_src = 2'b00;
    else if (jal)            pc_src = 2'b10;
    else if (branch && taken) pc_src = 2'b10;
    else                     pc_src = 2'b01;
  end

  assign misalign = HALT_ON_MISALIGN && (pc_next[1:0] != 2'b00);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    retire_d = retire_q;
    trap_d   = trap_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (imem_ready) state_d = EXEC;
      EXEC: begin
        // A stall masks a misaligned target, so no trap is raised while stalled.
        if (!stall) begin
          if (misalign) begin
            trap_d  = 1'b1;
            state_d = HALT;
          end else begin
            pc_d     = pc_next;
            retire_d = retire_q + 32'd1;
            state_d  = FETCH;
          end
        end
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_VECTOR;
      retire_q <= 32'd0;
      trap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      retire_q <= retire_d;
      trap_q   <= trap_d;
    end
  end

  assign imem_req   = (state_q == FETCH);
  assign exec_en    = (state_q == EXEC) && !stall && !misalign;
  assign pc         = pc_q;
  assign trap       = trap_q;
  assign state      = state_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: two instances (trapping and non-trapping
// on misalignment) share stimulus and are compared against a cycle-level reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, imem_ready, stall, branch, jal, jalr;
  logic [2:0]  funct3;
  logic        alu_zero, alu_lt, alu_ltu;
  logic [31:0] pc_next;

  logic [31:0] pcO [2];
  logic [1:0]  srcO [2];
  logic        reqO [2];
  logic        enO [2];
  logic        trapO [2];
  logic [1:0]  stO [2];
  logic [31:0] cntO [2];

  // Reference model state: index 0 traps on misalignment, index 1 does not.
  logic [31:0] mPc [2];
  logic [31:0] mCnt [2];
  logic [1:0]  mSt [2];
  logic        mTrap [2];

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(RV), .HALT_ON_MISALIGN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .stall(stall), .branch(branch),
    .jal(jal), .jalr(jalr), .funct3(funct3), .alu_zero(alu_zero), .alu_lt(alu_lt),
    .alu_ltu(alu_ltu), .pc_next(pc_next), .pc(pcO[0]), .pc_src(srcO[0]),
    .imem_req(reqO[0]), .exec_en(enO[0]), .trap(trapO[0]), .state(stO[0]),
    .retire_cnt(cntO[0])
  );

  pc_sequencer #(.RESET_VECTOR(RV), .HALT_ON_MISALIGN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .stall(stall), .branch(branch),
    .jal(jal), .jalr(jalr), .funct3(funct3), .alu_zero(alu_zero), .alu_lt(alu_lt),
    .alu_ltu(alu_ltu), .pc_next(pc_next), .pc(pcO[1]), .pc_src(srcO[1]),
    .imem_req(reqO[1]), .exec_en(enO[1]), .trap(trapO[1]), .state(stO[1]),
    .retire_cnt(cntO[1])
  );

  function automatic logic refTaken(input logic [2:0] f, input logic z, input logic lt,
                                    input logic ltu);
    case (f)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] expSrc();
    if (jalr) return 2'b00;
    if (jal) return 2'b10;
    if (branch && refTaken(funct3, alu_zero, alu_lt, alu_ltu)) return 2'b10;
    return 2'b01;
  endfunction

  function automatic logic expEn(input int d);
    return (mSt[d] == 2'd2) && !stall && !((d == 0) && (pc_next[1:0] != 2'b00));
  endfunction

  // Advance one clock: compute model next state from current inputs, then clock.
  task automatic tick();
    logic [31:0] nPc [2];
    logic [31:0] nCnt [2];
    logic [1:0]  nSt [2];
    logic        nTrap [2];
    for (int d = 0; d < 2; d++) begin
      nPc[d] = mPc[d]; nCnt[d] = mCnt[d]; nSt[d] = mSt[d]; nTrap[d] = mTrap[d];
      if (rst) begin
        nPc[d] = RV; nCnt[d] = 32'd0; nSt[d] = 2'd0; nTrap[d] = 1'b0;
      end else if (mSt[d] == 2'd0) begin
        nSt[d] = 2'd1;
      end else if (mSt[d] == 2'd1 && imem_ready) begin
        nSt[d] = 2'd2;
      end else if (mSt[d] == 2'd2 && !stall) begin
        if ((d == 0) && (pc_next[1:0] != 2'b00)) begin
          nTrap[d] = 1'b1; nSt[d] = 2'd3;
        end else begin
          nPc[d] = pc_next; nCnt[d] = mCnt[d] + 32'd1; nSt[d] = 2'd1;
        end
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      mPc[d] = nPc[d]; mCnt[d] = nCnt[d]; mSt[d] = nSt[d]; mTrap[d] = nTrap[d];
    end
    @(negedge clk);
  endtask

  task automatic clearCtl();
    stall = 1'b0; branch = 1'b0; jal = 1'b0; jalr = 1'b0; funct3 = 3'd0;
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
  endtask

  task automatic goExec();
    clearCtl();
    imem_ready = 1'b1;
    pc_next = mPc[0] + 32'd4;
    for (int i = 0; i < 4 && mSt[0] != 2'd2; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ready = 1'b0; pc_next = 32'h0000_0abc; clearCtl();
    tick(); tick();
    #1;
    for (int d = 0; d < 2; d++) begin
      nChecks++;
      if (pcO[d] !== RV) begin nFails++; $display("[TB] FAIL reset_pc[%0d]: got %h expected %h", d, pcO[d], RV); end
      nChecks++;
      if (stO[d] !== 2'd0) begin nFails++; $display("[TB] FAIL reset_state[%0d]: got %0d expected 0", d, stO[d]); end
      nChecks++;
      if (trapO[d] !== 1'b0 || cntO[d] !== 32'd0) begin
        nFails++; $display("[TB] FAIL reset_trap_cnt[%0d]: got trap=%b cnt=%h expected 0/0", d, trapO[d], cntO[d]);
      end
      nChecks++;
      if (reqO[d] !== 1'b0 || enO[d] !== 1'b0) begin
        nFails++; $display("[TB] FAIL reset_idle_outs[%0d]: got req=%b en=%b expected 0/0", d, reqO[d], enO[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    clearCtl();
    imem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pc_next = mPc[0] + 32'd4;
      #1;
      nChecks++;
      if (stO[0] !== mSt[0] || pcO[0] !== mPc[0] || cntO[0] !== mCnt[0]) begin
        nFails++;
        $display("[TB] FAIL seq_regs cyc%0d: got st=%0d pc=%h cnt=%0d expected st=%0d pc=%h cnt=%0d",
                 i, stO[0], pcO[0], cntO[0], mSt[0], mPc[0], mCnt[0]);
      end
      nChecks++;
      if (srcO[0] !== 2'b01 || reqO[0] !== (mSt[0] == 2'd1) || enO[0] !== expEn(0)) begin
        nFails++;
        $display("[TB] FAIL seq_comb cyc%0d: got src=%b req=%b en=%b expected src=01 req=%b en=%b",
                 i, srcO[0], reqO[0], enO[0], mSt[0] == 2'd1, expEn(0));
      end
      tick();
    end
  endtask

  task automatic test_branches();
    logic [31:0] target;
    for (int f = 0; f < 8; f++) begin
      for (int r = 0; r < 4; r++) begin
        goExec();
        branch = 1'b1; funct3 = 3'(f);
        alu_zero = 1'($urandom); alu_lt = 1'($urandom); alu_ltu = 1'($urandom);
        if (f == 0 && r == 0) alu_zero = 1'b1;
        target = (f == 0 && r == 0) ? 32'h40 : {$urandom_range(0, 32'h3FFF), 2'b00};
        pc_next = (expSrc() == 2'b10) ? target : mPc[0] + 32'd4;
        #1;
        nChecks++;
        if (srcO[0] !== expSrc()) begin
          nFails++;
          $display("[TB] FAIL branch_src f=%0d z=%b lt=%b ltu=%b: got %b expected %b",
                   f, alu_zero, alu_lt, alu_ltu, srcO[0], expSrc());
        end
        tick();
        nChecks++;
        if (pcO[0] !== mPc[0] || cntO[0] !== mCnt[0]) begin
          nFails++;
          $display("[TB] FAIL branch_pc f=%0d: got pc=%h cnt=%0d expected pc=%h cnt=%0d",
                   f, pcO[0], cntO[0], mPc[0], mCnt[0]);
        end
      end
    end
  endtask

  task automatic test_jumps();
    goExec();
    jalr = 1'b1; jal = 1'b1; pc_next = 32'h100;
    #1;
    nChecks++;
    if (srcO[0] !== 2'b00) begin nFails++; $display("[TB] FAIL jalr_over_jal_src: got %b expected 00", srcO[0]); end
    tick();
    nChecks++;
    if (pcO[0] !== 32'h100) begin nFails++; $display("[TB] FAIL jalr_pc: got %h expected 00000100", pcO[0]); end
    goExec();
    jal = 1'b1; branch = 1'b1; funct3 = 3'd2; pc_next = 32'h200;
    #1;
    nChecks++;
    if (srcO[0] !== 2'b10) begin nFails++; $display("[TB] FAIL jal_src: got %b expected 10", srcO[0]); end
    tick();
  endtask

  task automatic test_wait_stall();
    logic [31:0] heldPc, heldCnt;
    goExec();
    tick();
    imem_ready = 1'b0;
    heldPc = mPc[0]; heldCnt = mCnt[0];
    for (int i = 0; i < 3; i++) begin
      #1;
      nChecks++;
      if (pcO[0] !== heldPc || reqO[0] !== 1'b1 || stO[0] !== 2'd1) begin
        nFails++;
        $display("[TB] FAIL fetch_wait cyc%0d: got pc=%h req=%b st=%0d expected pc=%h req=1 st=1",
                 i, pcO[0], reqO[0], stO[0], heldPc);
      end
      tick();
    end
    imem_ready = 1'b1;
    tick();
    stall = 1'b1; imem_ready = 1'b0; pc_next = heldPc + 32'd4;
    for (int i = 0; i < 2; i++) begin
      #1;
      nChecks++;
      if (enO[0] !== 1'b0 || stO[0] !== 2'd2 || cntO[0] !== heldCnt || pcO[0] !== heldPc) begin
        nFails++;
        $display("[TB] FAIL stall cyc%0d: got en=%b st=%0d cnt=%0d pc=%h expected en=0 st=2 cnt=%0d pc=%h",
                 i, enO[0], stO[0], cntO[0], pcO[0], heldCnt, heldPc);
      end
      tick();
    end
    stall = 1'b0;
    #1;
    nChecks++;
    if (enO[0] !== 1'b1) begin nFails++; $display("[TB] FAIL stall_release_en: got %b expected 1", enO[0]); end
    tick();
    nChecks++;
    if (cntO[0] !== heldCnt + 32'd1 || pcO[0] !== heldPc + 32'd4) begin
      nFails++;
      $display("[TB] FAIL stall_release_retire: got cnt=%0d pc=%h expected cnt=%0d pc=%h",
               cntO[0], pcO[0], heldCnt + 32'd1, heldPc + 32'd4);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] heldPc;
    goExec();
    heldPc = mPc[0];
    stall = 1'b1; pc_next = 32'h102;
    #1;
    nChecks++;
    if (enO[0] !== 1'b0) begin nFails++; $display("[TB] FAIL misalign_stall_en: got %b expected 0", enO[0]); end
    tick();
    nChecks++;
    if (trapO[0] !== 1'b0 || stO[0] !== 2'd2) begin
      nFails++; $display("[TB] FAIL misalign_stall_notrap: got trap=%b st=%0d expected 0/2", trapO[0], stO[0]);
    end
    stall = 1'b0;
    #1;
    nChecks++;
    if (enO[0] !== 1'b0 || enO[1] !== 1'b1) begin
      nFails++; $display("[TB] FAIL misalign_en: got en0=%b en1=%b expected 0/1", enO[0], enO[1]);
    end
    tick();
    nChecks++;
    if (trapO[0] !== 1'b1 || stO[0] !== 2'd3 || pcO[0] !== heldPc || cntO[0] !== mCnt[0]) begin
      nFails++;
      $display("[TB] FAIL misalign_halt: got trap=%b st=%0d pc=%h cnt=%0d expected 1/3/%h/%0d",
               trapO[0], stO[0], pcO[0], cntO[0], heldPc, mCnt[0]);
    end
    nChecks++;
    if (pcO[1] !== 32'h102 || trapO[1] !== 1'b0) begin
      nFails++; $display("[TB] FAIL misalign_accept: got pc=%h trap=%b expected 00000102/0", pcO[1], trapO[1]);
    end
    imem_ready = 1'b1; pc_next = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      nChecks++;
      if (stO[0] !== 2'd3 || reqO[0] !== 1'b0 || enO[0] !== 1'b0 || pcO[0] !== heldPc || trapO[0] !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL halt_frozen cyc%0d: got st=%0d req=%b en=%b pc=%h trap=%b",
                 i, stO[0], reqO[0], enO[0], pcO[0], trapO[0]);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    nChecks++;
    if (pcO[0] !== RV || trapO[0] !== 1'b0 || stO[0] !== 2'd0) begin
      nFails++; $display("[TB] FAIL halt_reset: got pc=%h trap=%b st=%0d expected %h/0/0", pcO[0], trapO[0], stO[0], RV);
    end
  endtask

  task automatic test_reset_in_exec();
    goExec(); tick(); goExec();
    rst = 1'b1; pc_next = mPc[0] + 32'd4;
    tick();
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      nChecks++;
      if (cntO[d] !== 32'd0 || pcO[d] !== RV || stO[d] !== 2'd0) begin
        nFails++;
        $display("[TB] FAIL reset_in_exec[%0d]: got cnt=%0d pc=%h st=%0d expected 0/%h/0", d, cntO[d], pcO[d], stO[d], RV);
      end
    end
  endtask

  task automatic test_wrap();
    goExec();
    stall = 1'b1;
    force dut0.retire_q = 32'hFFFF_FFFF;
    mCnt[0] = 32'hFFFF_FFFF;
    tick();
    release dut0.retire_q;
    stall = 1'b0; pc_next = mPc[0] + 32'd4;
    #1;
    nChecks++;
    if (cntO[0] !== 32'hFFFF_FFFF) begin nFails++; $display("[TB] FAIL wrap_preload: got %h expected ffffffff", cntO[0]); end
    tick();
    nChecks++;
    if (cntO[0] !== 32'd0 || cntO[0] !== mCnt[0]) begin
      nFails++; $display("[TB] FAIL wrap_cnt: got %h expected 00000000", cntO[0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      imem_ready = 1'($urandom); stall = ($urandom_range(0, 2) == 0);
      branch = 1'($urandom); jal = ($urandom_range(0, 3) == 0); jalr = ($urandom_range(0, 3) == 0);
      funct3 = 3'($urandom); alu_zero = 1'($urandom); alu_lt = 1'($urandom); alu_ltu = 1'($urandom);
      pc_next = {$urandom_range(0, 32'h3FFF), 2'b00};
      #1;
      for (int d = 0; d < 2; d++) begin
        nChecks++;
        if (pcO[d] !== mPc[d] || cntO[d] !== mCnt[d] || stO[d] !== mSt[d] || trapO[d] !== mTrap[d] ||
            srcO[d] !== expSrc() || reqO[d] !== (mSt[d] == 2'd1) || enO[d] !== expEn(d)) begin
          nFails++;
          $display("[TB] FAIL random[%0d] cyc%0d: got pc=%h cnt=%0d st=%0d trap=%b src=%b req=%b en=%b expected pc=%h cnt=%0d st=%0d trap=%b src=%b req=%b en=%b",
                   d, i, pcO[d], cntO[d], stO[d], trapO[d], srcO[d], reqO[d], enO[d],
                   mPc[d], mCnt[d], mSt[d], mTrap[d], expSrc(), mSt[d] == 2'd1, expEn(d));
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      mPc[d] = RV; mCnt[d] = 32'd0; mSt[d] = 2'd0; mTrap[d] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_sequential();
    test_branches();
    test_jumps();
    test_wait_stall();
    test_misalign();
    test_reset_in_exec();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
